// File: rtl/multicore_out_collector.sv
// Merges single-cycle per-core result strobes into one tagged valid/ready stream via one-entry hold regs,
// a round-robin arbiter and a FWFT FIFO; strobe-to-out_valid latency 2 cycles; a strobe to a busy hold reg is dropped and counted.

module multicore_out_collector_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_dat,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head_dat,
    output logic                     o_vld,
    output logic [$clog2(DEPTH):0]   o_fill
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_fill;
    logic          w_pop;
    logic          w_push;

    assign w_pop  = i_pop && (r_fill != '0);
    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign w_push = i_push && ((r_fill != FULL) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + (AW+1)'(1);
                2'b01:   r_fill <= r_fill - (AW+1)'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wptr] <= i_push_dat;
    end

    assign o_vld      = (r_fill != '0);
    assign o_head_dat = o_vld ? r_mem[r_rptr] : '0;
    assign o_fill     = r_fill;
endmodule

module multicore_out_collector #(
    parameter int N_CORES = 26,
    parameter int DATA_W  = 31,
    parameter int DEPTH   = 16,
    parameter int CORE_W  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CORES*DATA_W-1:0]   core_data,
    input  logic [N_CORES*4-1:0]        core_en,
    output logic [DATA_W-1:0]           out_data,
    output logic [CORE_W-1:0]           out_core,
    output logic [3:0]                  out_port,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      fill,
    output logic                        ovf,
    output logic [15:0]                 drop_cnt
);
    localparam int FW = $clog2(DEPTH) + 1;
    localparam int EW = DATA_W + CORE_W + 4;
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    logic [N_CORES-1:0] r_hold_vld;
    logic [DATA_W-1:0]  r_hold_dat  [N_CORES];
    logic [3:0]         r_hold_port [N_CORES];
    logic [CORE_W-1:0]  r_ptr;
    logic               r_ovf;
    logic [15:0]        r_drop_cnt;

    logic               w_found;
    logic [CORE_W-1:0]  w_gnt_idx;
    logic [CORE_W:0]    w_cand;
    logic               w_gnt;
    logic [CORE_W-1:0]  w_ptr_nxt;
    logic               w_pop;
    logic [N_CORES-1:0] w_load;
    logic [5:0]         w_drop_n;
    logic [16:0]        w_drop_sum;
    logic [15:0]        w_drop_sat;
    logic [EW-1:0]      w_push_dat;
    logic [EW-1:0]      w_head_dat;
    logic               w_fifo_vld;
    logic [FW-1:0]      w_fifo_fill;

    // Round-robin search: first valid hold reg at or after r_ptr, wrapping at N_CORES.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < N_CORES; k++) begin
            w_cand = {1'b0, r_ptr} + (CORE_W+1)'(k);
            if (w_cand >= (CORE_W+1)'(N_CORES)) w_cand = w_cand - (CORE_W+1)'(N_CORES);
            if (!w_found && r_hold_vld[w_cand[CORE_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand[CORE_W-1:0];
            end
        end
    end

    assign w_pop     = w_fifo_vld && out_ready;
    assign w_gnt     = w_found && ((w_fifo_fill != FULL) || w_pop);
    assign w_ptr_nxt = (w_gnt_idx == CORE_W'(N_CORES-1)) ? '0 : w_gnt_idx + CORE_W'(1);
    assign w_push_dat = {r_hold_dat[w_gnt_idx], w_gnt_idx, r_hold_port[w_gnt_idx]};

    // A hold reg being granted this edge is free for a fresh strobe, so steady streams never drop.
    always_comb begin
        w_load   = '0;
        w_drop_n = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (core_en[i*4 +: 4] != 4'd0) begin
                if (!r_hold_vld[i] || (w_gnt && (w_gnt_idx == CORE_W'(i)))) w_load[i] = 1'b1;
                else                                                       w_drop_n  = w_drop_n + 6'd1;
            end
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_n);
    assign w_drop_sat = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_vld <= '0;
            r_ptr      <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (w_load[i]) begin
                    r_hold_vld[i]  <= 1'b1;
                    r_hold_dat[i]  <= core_data[i*DATA_W +: DATA_W];
                    r_hold_port[i] <= core_en[i*4 +: 4];
                end else if (w_gnt && (w_gnt_idx == CORE_W'(i))) begin
                    r_hold_vld[i]  <= 1'b0;
                end
            end
            if (w_gnt) r_ptr <= w_ptr_nxt;
            if (w_drop_n != 6'd0) begin
                r_ovf      <= 1'b1;
                r_drop_cnt <= w_drop_sat;
            end
        end
    end

    multicore_out_collector_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_gnt),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_vld      (w_fifo_vld),
        .o_fill     (w_fifo_fill)
    );

    assign {out_data, out_core, out_port} = w_head_dat;
    assign out_valid = w_fifo_vld;
    assign fill      = w_fifo_fill;
    assign ovf       = r_ovf;
    assign drop_cnt  = r_drop_cnt;
endmodule

// File: doc/multicore_out_collector.md
# multicore_out_collector

Downstream stage of the multi-core `rede` array: gathers the per-core result words (`io_outN`, `out_enN`) that the cores emit as single-cycle strobes, and merges them into one ordered stream. Each core gets a one-entry holding register; a round-robin arbiter drains the holding registers into a shared FIFO, so simultaneous strobes are never lost. The FIFO drives a valid/ready stream tagged with core index and output port for the host/IO side.

## Interface
- `N_CORES`, 26, number of cores attached (1..32)
- `DATA_W`, 31, signed result word width
- `DEPTH`, 16, FIFO depth in entries (power of two, ≥2)
- `CORE_W`, 5, core-index width, ≥ clog2(N_CORES)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `core_data`  in  N_CORES*DATA_W  packed `io_out` words, core i at bits [i*DATA_W +: DATA_W]
- `core_en`  in  N_CORES*4  packed `out_en` codes, core i at [i*4 +: 4]; 0 = idle, 1..15 = output port number
- `out_data`  out  DATA_W  head-of-FIFO result word
- `out_core`  out  CORE_W  index of core that produced it
- `out_port`  out  4  port code (`out_en` value) captured with it
- `out_valid`  out  1  head entry present
- `out_ready`  in  1  consumer accepts head when `out_valid & out_ready`
- `fill`  out  clog2(DEPTH)+1  current FIFO occupancy
- `ovf`  out  1  sticky: a core strobe was dropped
- `drop_cnt`  out  16  saturating count of dropped strobes

## Operation
- Capture: on each edge, for every core i with `core_en[i] != 0`: if hold[i] empty, or being granted this same cycle, load hold[i] <= {data, port}, valid. Otherwise the strobe is dropped: `ovf` <= 1, `drop_cnt` += 1 (saturates at 16'hFFFF). Multiple drops in one cycle add their full count (saturating).
- A core strobing on consecutive cycles with an uncontended, non-full FIFO loses nothing (free-same-cycle rule).
- Arbiter: one grant per cycle among valid hold regs, round-robin. Search starts at `ptr`; after a grant to core g, `ptr` <= (g+1) mod N_CORES; no grant -> `ptr` unchanged. Reset `ptr` = 0.
- Grant allowed only if `fill < DEPTH`, or a pop occurs in the same cycle (push+pop when full is legal, `fill` unchanged).
- Granted entry {data, g, port} is written to the FIFO tail; hold[g] cleared unless refilled that cycle.
- FIFO: first-word fall-through; `out_*` reflect head entry combinationally from storage; pop on `out_valid & out_ready`. Pop when empty ignored. Read/write pointers wrap modulo DEPTH; `fill` = push - pop accounting, range 0..DEPTH.
- Signed data passed through bit-exact; no arithmetic on payload.
- Reset values: all hold regs invalid, FIFO empty, `out_valid`=0, `fill`=0, `ovf`=0, `drop_cnt`=0, `ptr`=0. `out_data/out_core/out_port` are don't-care while `out_valid`=0 but must not be X after reset (drive 0 when empty).
- Reset asserted mid-stream discards all hold and FIFO contents on that edge; strobes in the reset cycle are ignored and not counted as drops.

## Timing
- Strobe at edge t -> hold valid after t; grant at edge t+1 -> `out_valid` high after t+1 (latency 2 cycles, idle system).
- k simultaneous strobes, empty FIFO, `out_ready`=1: outputs appear on k consecutive cycles, in round-robin order from `ptr`.
- Throughput: 1 entry/cycle in and out.
- `ovf` and `drop_cnt` update on the edge of the dropped strobe.
- `fill` updates on the push/pop edge.

## Test plan
- Single strobe: reset, core 3 `core_en`=1, data -5 at cycle 10 -> `out_valid` after cycle 11 with data -5, core 3, port 1; pop -> `fill` 0.
- Collision: cores 0, 7, 25 strobe same cycle, `ptr`=0 -> outputs in order 0, 7, 25 on consecutive cycles; next grant search starts at 0 (after 25 wraps).
- Back-to-back: core 5 strobes 4 consecutive cycles, ready=1 -> 4 outputs in order, `ovf`=0.
- Backpressure/full: `out_ready`=0, 20 strobes from distinct cores over 20 cycles -> `fill` stops at 16, 4 entries remain in hold regs; next strobe to a held core sets `ovf`=1, `drop_cnt`=1; releasing ready drains 20 entries in order.
- Full with simultaneous push+pop: `fill`=16, ready=1, hold valid -> `fill` stays 16 each cycle, no drop.
- Reset mid-operation: `fill`=9, holds valid, assert `rst` one cycle -> `out_valid`=0, `fill`=0, `ovf`=0, `drop_cnt`=0, no stale entry reappears.
